counter_param: RTL and testbench
================================

COUNTER_PARAM -- requirements
Module: counter_param

Parameters
REQ-001 The module SHALL have parameter WIDTH, default 8: counter and stop_at width, legal range 2..32.
REQ-002 The module SHALL have parameter DIV, default 1: prescale factor, so the count steps once per DIV un-paused RUN cycles; legal range 1..65535.

Interface
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The module SHALL have port start, input, 1 bit: level run request; low forces IDLE.
REQ-006 The module SHALL have port pause, input, 1 bit: freezes count and prescaler while high.
REQ-007 The module SHALL have port mode, input, 2 bits: 00 saturate-up, 01 wrap-up, 10 saturate-down, 11 wrap-down; sampled only on IDLE->RUN.
REQ-008 The module SHALL have port stop_at, input, WIDTH bits: terminal bound, live (not latched).
REQ-009 The module SHALL have port count, output, WIDTH bits: registered, unsigned count value.
REQ-010 The module SHALL have port running, output, 1 bit: high when state is RUN.
REQ-011 The module SHALL have port done, output, 1 bit: high when state is DONE.
REQ-012 The module SHALL have port wrap, output, 1 bit: registered 1-cycle pulse on each wrap event.

Function
REQ-013 Limit L SHALL be (2^WIDTH)-1 when stop_at==0, else stop_at-1, evaluated every cycle.
REQ-014 The FSM SHALL have states IDLE, RUN and DONE, with mode latched into mode_q on IDLE->RUN.
REQ-015 In IDLE: count=0; the prescaler is cleared; start=1 sampled -> next cycle RUN with count=init.
REQ-016 init SHALL be 0 for up modes and L for down modes.
REQ-017 If init is already the terminal value (saturate mode, L==0), IDLE with start=1 SHALL go directly to DONE with count=0.
REQ-018 Prescaler pre SHALL count 0..DIV-1 in RUN when pause=0; tick = (pre==DIV-1) && !pause; DIV=1 gives a tick every un-paused RUN cycle.
REQ-019 On tick in up modes, count SHALL increment.
REQ-020 On tick in down modes, count SHALL decrement.
REQ-021 Saturate modes: the tick that makes count reach the terminal value (L for up, 0 for down) SHALL move the FSM to DONE in the same edge.
REQ-022 In DONE, count SHALL hold its value until start is low.
REQ-023 Wrap-up: tick with count==L SHALL load count=0 and assert wrap the next cycle; the FSM stays in RUN.
REQ-024 Wrap-down: tick with count==0 SHALL load count=L and assert wrap the next cycle; the FSM stays in RUN.
REQ-025 Wrap modes SHALL never enter DONE.
REQ-026 Live stop_at shrink, count>L in RUN: saturate-up -> count=L and DONE next cycle.
REQ-027 Live stop_at shrink, count>L in RUN: wrap-up -> count=0 and wrap pulse next cycle.
REQ-028 Live stop_at shrink, count>L in RUN: down modes -> count=L next cycle; this clamp is independent of tick.
REQ-029 start=0 in any state SHALL force IDLE and count=0 next cycle, overriding pause, tick and clamp.
REQ-030 pause=1 in RUN SHALL hold count and pre, and SHALL suppress wrap.
REQ-031 The stop_at-shrink clamp SHALL still apply while paused.
REQ-032 Arithmetic SHALL be modulo 2^WIDTH; no intermediate wider than WIDTH+1 bits is visible at outputs.
REQ-033 running, done and wrap SHALL be registered, glitch-free, and mutually consistent with state.

Reset
REQ-034 reset=1 at a rising clk SHALL set state=IDLE, count=0, pre=0, mode_q=00, running=0, done=0 and wrap=0.
REQ-035 reset SHALL have priority over start and all other inputs.
REQ-036 Reset asserted mid-RUN or mid-DONE SHALL take effect at the next edge.
REQ-037 After reset release, operation SHALL resume only via IDLE with start=1.

Verification
REQ-038 WIDTH=8, DIV=1, mode=00, stop_at=5, start high: count 0,1,2,3,4 on successive cycles after RUN entry; done=1 with count=4; count holds at 4.
REQ-039 mode=01, stop_at=0, run to 255: next tick count=0; wrap high exactly one cycle; running stays 1.
REQ-040 mode=10, stop_at=3: RUN entry count=2, then 1, then 0 with done=1.
REQ-041 DIV=3, mode=00, stop_at=0: count steps every 3 cycles; a 2-cycle pause mid-period delays the next step by exactly 2 cycles.
REQ-042 mode=00, stop_at=10, count=7, stop_at changed to 4: next cycle count=3 and done=1.
REQ-043 Mid-RUN start=0 -> next cycle count=0, IDLE; separately, mid-RUN reset=1 -> all outputs 0 next cycle; start=1 then restarts from init.

Source files
------------

// File: rtl/counter_param.sv
// Prescaled up/down counter with saturate or wrap behaviour, a live terminal
// bound (stop_at) and a three-state IDLE/RUN/DONE control FSM.
module counter_param #(
   parameter int WIDTH = 8,
   parameter int DIV   = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             pause,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] stop_at,
   output logic [WIDTH-1:0] count,
   output logic             running,
   output logic             done,
   output logic             wrap
);

   localparam logic [1:0]  S_IDLE  = 2'b00;
   localparam logic [1:0]  S_RUN   = 2'b01;
   localparam logic [1:0]  S_DONE  = 2'b10;
   localparam logic [15:0] PRE_MAX = 16'(DIV - 1);

   logic [1:0]       state, state_nxt;
   logic [1:0]       mode_q, mode_nxt;
   logic [15:0]      pre, pre_nxt;
   logic [WIDTH-1:0] count_nxt;
   logic [WIDTH-1:0] lim;
   logic [WIDTH-1:0] init;
   logic             wrap_nxt;
   logic             tick;
   logic             down;
   logic             sat;

   always_comb begin
      lim       = (stop_at == '0) ? '1 : stop_at - WIDTH'(1);
      init      = mode[1] ? lim : '0;
      tick      = (state == S_RUN) && (pre == PRE_MAX) && !pause;
      down      = mode_q[1];
      sat       = !mode_q[0];
      state_nxt = state;
      mode_nxt  = mode_q;
      pre_nxt   = pre;
      count_nxt = count;
      wrap_nxt  = 1'b0;

      if (!start) begin
         state_nxt = S_IDLE;
         count_nxt = '0;
         pre_nxt   = '0;
      end else begin
         case (state)
            S_IDLE: begin
               mode_nxt = mode;
               pre_nxt  = '0;
               // Saturating run whose start value is already terminal finishes at once
               if (!mode[0] && lim == '0) begin
                  state_nxt = S_DONE;
                  count_nxt = '0;
               end else begin
                  state_nxt = S_RUN;
                  count_nxt = init;
               end
            end
            S_RUN: begin
               if (!pause)
                  pre_nxt = (pre == PRE_MAX) ? '0 : pre + 16'd1;
               // A shrunken bound clamps the count regardless of tick or pause
               if (count > lim) begin
                  if (down) begin
                     count_nxt = lim;
                  end else if (sat) begin
                     count_nxt = lim;
                     state_nxt = S_DONE;
                  end else begin
                     count_nxt = '0;
                     wrap_nxt  = !pause;
                  end
               end else if (tick) begin
                  if (!down) begin
                     if (count == lim) begin
                        if (sat) begin
                           state_nxt = S_DONE;
                        end else begin
                           count_nxt = '0;
                           wrap_nxt  = 1'b1;
                        end
                     end else begin
                        count_nxt = count + WIDTH'(1);
                        if (sat && count_nxt == lim)
                           state_nxt = S_DONE;
                     end
                  end else begin
                     if (count == '0) begin
                        if (sat) begin
                           state_nxt = S_DONE;
                        end else begin
                           count_nxt = lim;
                           wrap_nxt  = 1'b1;
                        end
                     end else begin
                        count_nxt = count - WIDTH'(1);
                        if (sat && count_nxt == '0)
                           state_nxt = S_DONE;
                     end
                  end
               end
               if (state_nxt != S_RUN)
                  pre_nxt = '0;
            end
            S_DONE: begin
               pre_nxt = '0;
            end
            default: begin
               state_nxt = S_IDLE;
               count_nxt = '0;
               pre_nxt   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= S_IDLE;
         mode_q  <= 2'b00;
         pre     <= '0;
         count   <= '0;
         running <= 1'b0;
         done    <= 1'b0;
         wrap    <= 1'b0;
      end else begin
         state   <= state_nxt;
         mode_q  <= mode_nxt;
         pre     <= pre_nxt;
         count   <= count_nxt;
         running <= (state_nxt == S_RUN);
         done    <= (state_nxt == S_DONE);
         wrap    <= wrap_nxt;
      end
   end

endmodule

// File: tb/tb_counter_param.sv
// Directed bench for counter_param: one DIV=1 instance and one DIV=3 instance
// sharing the same stimulus.
module tb_counter_param;

   logic       clk;
   logic       reset;
   logic       start;
   logic       pause;
   logic [1:0] mode;
   logic [7:0] stop_at;
   logic [7:0] count,  count3;
   logic       running, running3;
   logic       done,    done3;
   logic       wrap,    wrap3;

   int checks_total  = 0;
   int checks_passed = 0;

   counter_param #(.WIDTH(8), .DIV(1)) u_dut (
      .clk(clk), .reset(reset), .start(start), .pause(pause), .mode(mode),
      .stop_at(stop_at), .count(count), .running(running), .done(done), .wrap(wrap)
   );

   counter_param #(.WIDTH(8), .DIV(3)) u_dut3 (
      .clk(clk), .reset(reset), .start(start), .pause(pause), .mode(mode),
      .stop_at(stop_at), .count(count3), .running(running3), .done(done3), .wrap(wrap3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic go_idle();
      start = 1'b0;
      pause = 1'b0;
      step();
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b1; mode = 2'b00; stop_at = 8'd5;
      step();
      checks_total++;
      if ({count, running, done, wrap} !== 11'd0)
         $display("FAIL reset_outputs: got count=%0d run=%0b done=%0b wrap=%0b want all 0",
                  count, running, done, wrap);
      else checks_passed++;
      reset = 1'b0; start = 1'b0;
      step();
   endtask

   task automatic test_sat_up();
      logic [7:0] exp;
      mode = 2'b00; stop_at = 8'd5; start = 1'b1;
      for (int i = 0; i <= 4; i++) begin
         step();
         exp = 8'(i);
         checks_total++;
         if (count !== exp || running !== (i != 4) || done !== (i == 4))
            $display("FAIL sat_up_step%0d: got count=%0d run=%0b done=%0b want count=%0d run=%0b done=%0b",
                     i, count, running, done, exp, (i != 4), (i == 4));
         else checks_passed++;
      end
      step(); step();
      checks_total++;
      if (count !== 8'd4 || done !== 1'b1)
         $display("FAIL sat_up_hold: got count=%0d done=%0b want count=4 done=1", count, done);
      else checks_passed++;
      go_idle();
      checks_total++;
      if (count !== 8'd0 || done !== 1'b0)
         $display("FAIL sat_up_release: got count=%0d done=%0b want count=0 done=0", count, done);
      else checks_passed++;
   endtask

   task automatic test_wrap_up();
      int bad;
      mode = 2'b01; stop_at = 8'd0; start = 1'b1;
      step();
      bad = 0;
      for (int i = 1; i <= 255; i++) begin
         step();
         if (count !== 8'(i) || wrap !== 1'b0 || running !== 1'b1) bad++;
      end
      checks_total++;
      if (bad != 0)
         $display("FAIL wrap_up_ramp: got %0d bad cycles want 0 (last count=%0d)", bad, count);
      else checks_passed++;
      step();
      checks_total++;
      if (count !== 8'd0 || wrap !== 1'b1 || running !== 1'b1 || done !== 1'b0)
         $display("FAIL wrap_up_event: got count=%0d wrap=%0b run=%0b done=%0b want 0 1 1 0",
                  count, wrap, running, done);
      else checks_passed++;
      step();
      checks_total++;
      if (count !== 8'd1 || wrap !== 1'b0 || running !== 1'b1)
         $display("FAIL wrap_up_after: got count=%0d wrap=%0b run=%0b want 1 0 1", count, wrap, running);
      else checks_passed++;
      go_idle();
   endtask

   task automatic test_sat_down();
      logic [7:0] exp [3] = '{8'd2, 8'd1, 8'd0};
      mode = 2'b10; stop_at = 8'd3; start = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         checks_total++;
         if (count !== exp[i] || done !== (i == 2) || running !== (i != 2))
            $display("FAIL sat_down_step%0d: got count=%0d done=%0b run=%0b want count=%0d done=%0b",
                     i, count, done, running, exp[i], (i == 2));
         else checks_passed++;
      end
      go_idle();
   endtask

   task automatic test_wrap_down();
      logic [7:0] exp  [5] = '{8'd2, 8'd1, 8'd0, 8'd2, 8'd1};
      logic       expw [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      mode = 2'b11; stop_at = 8'd3; start = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         checks_total++;
         if (count !== exp[i] || wrap !== expw[i] || running !== 1'b1 || done !== 1'b0)
            $display("FAIL wrap_down_step%0d: got count=%0d wrap=%0b run=%0b want count=%0d wrap=%0b run=1",
                     i, count, wrap, running, exp[i], expw[i]);
         else checks_passed++;
      end
      go_idle();
   endtask

   task automatic test_prescale();
      logic [7:0] exp  [11] = '{8'd0, 8'd0, 8'd1, 8'd1, 8'd1, 8'd2, 8'd2, 8'd2, 8'd2, 8'd2, 8'd3};
      logic       pz   [11] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0};
      mode = 2'b00; stop_at = 8'd0; start = 1'b1;
      step();
      checks_total++;
      if (count3 !== 8'd0 || running3 !== 1'b1)
         $display("FAIL prescale_entry: got count=%0d run=%0b want 0 1", count3, running3);
      else checks_passed++;
      for (int i = 0; i < 11; i++) begin
         pause = pz[i];
         step();
         checks_total++;
         if (count3 !== exp[i])
            $display("FAIL prescale_edge%0d: got count=%0d want %0d", i + 1, count3, exp[i]);
         else checks_passed++;
      end
      go_idle();
   endtask

   task automatic test_shrink();
      mode = 2'b00; stop_at = 8'd10; start = 1'b1;
      for (int i = 0; i < 8; i++) step();
      checks_total++;
      if (count !== 8'd7 || running !== 1'b1)
         $display("FAIL shrink_pre: got count=%0d run=%0b want 7 1", count, running);
      else checks_passed++;
      stop_at = 8'd4;
      step();
      checks_total++;
      if (count !== 8'd3 || done !== 1'b1 || running !== 1'b0)
         $display("FAIL shrink_sat_up: got count=%0d done=%0b run=%0b want 3 1 0", count, done, running);
      else checks_passed++;
      go_idle();
      mode = 2'b10; stop_at = 8'd10; start = 1'b1;
      step();
      pause = 1'b1; stop_at = 8'd5;
      step();
      checks_total++;
      if (count !== 8'd4 || running !== 1'b1)
         $display("FAIL shrink_down_paused: got count=%0d run=%0b want 4 1", count, running);
      else checks_passed++;
      step();
      checks_total++;
      if (count !== 8'd4)
         $display("FAIL pause_hold: got count=%0d want 4", count);
      else checks_passed++;
      pause = 1'b0;
      step();
      checks_total++;
      if (count !== 8'd3)
         $display("FAIL pause_release: got count=%0d want 3", count);
      else checks_passed++;
      go_idle();
   endtask

   task automatic test_zero_limit();
      mode = 2'b00; stop_at = 8'd1; start = 1'b1;
      step();
      checks_total++;
      if (count !== 8'd0 || done !== 1'b1 || running !== 1'b0)
         $display("FAIL zero_limit: got count=%0d done=%0b run=%0b want 0 1 0", count, done, running);
      else checks_passed++;
      go_idle();
   endtask

   task automatic test_abort();
      mode = 2'b00; stop_at = 8'd0; start = 1'b1;
      step(); step(); step();
      start = 1'b0;
      step();
      checks_total++;
      if (count !== 8'd0 || running !== 1'b0 || done !== 1'b0)
         $display("FAIL abort_start_low: got count=%0d run=%0b done=%0b want 0 0 0", count, running, done);
      else checks_passed++;
      start = 1'b1;
      step(); step(); step();
      reset = 1'b1;
      step();
      checks_total++;
      if ({count, running, done, wrap} !== 11'd0)
         $display("FAIL abort_reset: got count=%0d run=%0b done=%0b wrap=%0b want all 0",
                  count, running, done, wrap);
      else checks_passed++;
      reset = 1'b0;
      step();
      checks_total++;
      if (count !== 8'd0 || running !== 1'b1)
         $display("FAIL restart_entry: got count=%0d run=%0b want 0 1", count, running);
      else checks_passed++;
      step();
      checks_total++;
      if (count !== 8'd1)
         $display("FAIL restart_step: got count=%0d want 1", count);
      else checks_passed++;
      go_idle();
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; pause = 1'b0; mode = 2'b00; stop_at = 8'd0;
      test_reset();
      test_sat_up();
      test_wrap_up();
      test_sat_down();
      test_wrap_down();
      test_prescale();
      test_shrink();
      test_zero_limit();
      test_abort();
      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule
